decoder4_ctrl: RTL and testbench
================================

Name: decoder4_ctrl

Overview:
Sequencer for one decoder4 pattern-detector instance. Accepts a parallel pattern over a valid/ready handshake and shifts it MSB-first into the decoder on prgm, holding enable high for exactly PAT_W cycles. It then blanks stale matches while the decoder's signal shift register refills, and forwards the serial signal stream. Decoder matches are counted in a saturating counter. Sits between the config/host logic and decoder4; it is the only driver of the decoder's prgm, enable and sig inputs.

Parameters:
PAT_W, 4, pattern length in bits; equals decoder4 pattern register width.
CNT_W, 8, match counter width.

Ports:
clk  in  1  rising-edge clock; also drives decoder4.
clr  in  1  asynchronous, active-low reset (0 = reset).
cfg_pattern  in  PAT_W  pattern to program; bit PAT_W-1 is sent first.
cfg_valid  in  1  pattern offer.
cfg_ready  out  1  controller can accept a pattern.
sig_in  in  1  serial signal stream, one bit per cycle.
dec_prgm  out  1  to decoder4 prgm.
dec_enable  out  1  to decoder4 enable; high only while loading.
dec_sig  out  1  to decoder4 sig.
dec_out  in  1  from decoder4 out.
armed  out  1  in RUN; matches are being counted.
match_pulse  out  1  one-cycle flag for each counted match.
match_count  out  CNT_W  saturating count of matches since the last accepted pattern.

Behaviour:
- All outputs are registered except cfg_ready, which is decoded from state.
- Reset (clr=0, async): state=IDLE; dec_prgm, dec_enable, dec_sig, armed, match_pulse = 0; match_count = 0; shift register and bit counter = 0.
- States: IDLE, LOAD, FLUSH, RUN.
- cfg_ready = 1 in IDLE and RUN; 0 in LOAD and FLUSH.
- A pattern is accepted on a cycle with cfg_valid & cfg_ready. In that cycle:
  - cfg_pattern is captured into the shift register.
  - match_count is cleared and armed is cleared.
  - Next state is LOAD.
- LOAD, PAT_W cycles (i = 0..PAT_W-1):
  - dec_enable=1; dec_prgm = pattern bit PAT_W-1-i; dec_sig=0.
  - After the last bit, go to FLUSH; dec_enable is 0 from the next cycle.
  - dec_enable is never high for more or fewer than PAT_W consecutive cycles per accept.
- FLUSH, PAT_W cycles:
  - dec_enable=0; dec_sig <= sig_in (one-cycle register delay); dec_out is ignored.
  - Then go to RUN and set armed=1.
- RUN:
  - dec_sig <= sig_in.
  - Each cycle dec_out=1 sets match_pulse=1 the next cycle and increments match_count.
  - match_count saturates at 2^CNT_W-1 and never wraps.
- Latency: accept at edge k; decoder sees first prgm bit at edge k+2; armed=1 from edge k+1+2·PAT_W.
- Simultaneous accept and dec_out=1 in RUN: the new pattern wins; that match is not counted and match_pulse stays 0.
- cfg_valid while cfg_ready=0 is held off; there is no loss and no partial reload.
- In IDLE: dec_sig=0, dec_out is ignored, and the counter holds.
- Reset mid-LOAD or mid-FLUSH: returns to IDLE with the decoder contents undefined. A new accept is required before any counting.
- Total implementation: state register, log2(PAT_W)+1 bit counter, PAT_W shift register, CNT_W counter.

Optional Feature:
Macro: DEC4_CTRL_OVF_EN.
- Defined: adds output port cnt_ovf (1 bit, reset 0). cnt_ovf is set when a match is detected in RUN while match_count already equals 2^CNT_W-1. It is sticky until the next accepted pattern or reset.
- Undefined: the cnt_ovf port and its logic are absent; saturation behaviour is unchanged.

Test Plan:
1. Reset then program: release clr, hold cfg_valid=1 with cfg_pattern=4'b1010. Required response:
   - Accepted on the first cycle with cfg_ready=1.
   - dec_enable high exactly 4 cycles, with dec_prgm = 1,0,1,0.
   - cfg_ready low for 8 cycles, then armed=1.
2. Match counting: after test 1, drive sig_in = 16'b0101000101000000 MSB-first into a behavioural decoder4 model. Required response: match_count=2, and exactly 2 match_pulse cycles, each one cycle after the model's dec_out.
3. Flush blanking: force dec_out=1 throughout LOAD and FLUSH. Required response: match_count stays 0 and match_pulse stays 0 until armed rises.
4. Reprogram collision: in RUN with match_count=5, accept cfg_pattern=4'b0110 in the same cycle as dec_out=1. Required response:
   - match_count=0 and match_pulse=0.
   - New LOAD sequence dec_prgm = 0,1,1,0.
5. Saturation (CNT_W=8): hold dec_out=1 for 300 RUN cycles. Required response: match_count stops at 255. With DEC4_CTRL_OVF_EN, cnt_ovf rises on the 256th match and holds.
6. Async reset mid-LOAD: pull clr low between clock edges after 2 prgm bits. Required response:
   - Outputs 0 immediately, state IDLE, no further dec_enable.
   - After clr is released, a fresh accept produces a full 4-cycle load.

Source files
------------

// File: rtl/decoder4_ctrl.sv
// Sequencer for one decoder4 pattern detector: loads a pattern MSB-first, blanks
// stale matches during refill, then counts matches. Optional cnt_ovf via DEC4_CTRL_OVF_EN.
module decoder4_ctrl #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             sig_in,
  output logic             dec_prgm,
  output logic             dec_enable,
  output logic             dec_sig,
  input  logic             dec_out,
  output logic             armed,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count
`ifdef DEC4_CTRL_OVF_EN
  ,
  output logic             cnt_ovf
`endif
);

  localparam int              BC_W     = $clog2(PAT_W) + 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   shift_q, shift_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic               dec_prgm_q, dec_prgm_d;
  logic               dec_enable_q, dec_enable_d;
  logic               dec_sig_q, dec_sig_d;
  logic               armed_q, armed_d;
  logic               match_pulse_q, match_pulse_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               accept;
`ifdef DEC4_CTRL_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  assign cfg_ready = (state_q == IDLE) || (state_q == RUN);
  assign accept    = cfg_valid && cfg_ready;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    dec_prgm_d    = 1'b0;
    dec_enable_d  = 1'b0;
    dec_sig_d     = 1'b0;
    armed_d       = armed_q;
    match_pulse_d = 1'b0;
    count_d       = count_q;
`ifdef DEC4_CTRL_OVF_EN
    ovf_d         = ovf_q;
`endif

    unique case (state_q)
      IDLE: ;
      LOAD: begin
        dec_enable_d = 1'b1;
        dec_prgm_d   = shift_q[PAT_W-1];
        shift_d      = {shift_q[PAT_W-2:0], 1'b0};
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = FLUSH;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      // Decoder's signal register still holds old bits here, so dec_out is ignored.
      FLUSH: begin
        dec_sig_d = sig_in;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          state_d   = RUN;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      RUN: begin
        dec_sig_d = sig_in;
        armed_d   = 1'b1;
        if (armed_q && dec_out) begin
          match_pulse_d = 1'b1;
          count_d       = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
`ifdef DEC4_CTRL_OVF_EN
          if (count_q == CNT_MAX) ovf_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // A new pattern overrides anything RUN decided this cycle, including a match.
    if (accept) begin
      state_d       = LOAD;
      shift_d       = cfg_pattern;
      bit_cnt_d     = '0;
      dec_sig_d     = 1'b0;
      armed_d       = 1'b0;
      match_pulse_d = 1'b0;
      count_d       = '0;
`ifdef DEC4_CTRL_OVF_EN
      ovf_d         = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      dec_prgm_q    <= 1'b0;
      dec_enable_q  <= 1'b0;
      dec_sig_q     <= 1'b0;
      armed_q       <= 1'b0;
      match_pulse_q <= 1'b0;
      count_q       <= '0;
`ifdef DEC4_CTRL_OVF_EN
      ovf_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      dec_prgm_q    <= dec_prgm_d;
      dec_enable_q  <= dec_enable_d;
      dec_sig_q     <= dec_sig_d;
      armed_q       <= armed_d;
      match_pulse_q <= match_pulse_d;
      count_q       <= count_d;
`ifdef DEC4_CTRL_OVF_EN
      ovf_q         <= ovf_d;
`endif
    end
  end

  assign dec_prgm    = dec_prgm_q;
  assign dec_enable  = dec_enable_q;
  assign dec_sig     = dec_sig_q;
  assign armed       = armed_q;
  assign match_pulse = match_pulse_q;
  assign match_count = count_q;
`ifdef DEC4_CTRL_OVF_EN
  assign cnt_ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_decoder4_ctrl.sv
// Self-checking bench for decoder4_ctrl: a table-driven programming sequence, directed
// corner cases, and random traffic against an age-since-accept reference model.
module tb_decoder4_ctrl;

  localparam int PAT_W   = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  logic             clk = 1'b0;
  logic             clr = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic             sig_in = 1'b0;
  logic             dec_prgm, dec_enable, dec_sig, dec_out;
  logic             armed, match_pulse;
  logic [CNT_W-1:0] match_count;
`ifdef DEC4_CTRL_OVF_EN
  logic             cnt_ovf;
`endif

  decoder4_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .cfg_pattern(cfg_pattern), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .sig_in(sig_in), .dec_prgm(dec_prgm),
    .dec_enable(dec_enable), .dec_sig(dec_sig), .dec_out(dec_out),
    .armed(armed), .match_pulse(match_pulse), .match_count(match_count)
`ifdef DEC4_CTRL_OVF_EN
    , .cnt_ovf(cnt_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural decoder4: pattern register loads on enable, signal register always shifts.
  logic [PAT_W-1:0] dPat = '0;
  logic [PAT_W-1:0] dSr  = '0;
  logic             useDecModel = 1'b0;
  logic             decOutDrv   = 1'b0;
  always @(posedge clk) begin
    if (dec_enable) dPat <= {dPat[PAT_W-2:0], dec_prgm};
    dSr <= {dSr[PAT_W-2:0], dec_sig};
  end
  assign dec_out = useDecModel ? (dSr == dPat) : decOutDrv;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: everything is derived from the number of edges since the last accept.
  bit               mIdle = 1'b1;
  int               mAge  = 0;
  logic [PAT_W-1:0] mPat  = '0;
  int               mCount = 0;
  bit               mOvf = 1'b0, mPulse = 1'b0, mSig = 1'b0;

  typedef struct {
    logic             valid;
    logic [PAT_W-1:0] pattern;
    logic             expReady;
    logic             expEnable;
    logic             expPrgm;
    logic             expArmed;
  } vec_t;
  vec_t vecs[11];

  task automatic cmp(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic void modelReset();
    mIdle = 1'b1; mAge = 0; mCount = 0; mOvf = 1'b0; mPulse = 1'b0; mSig = 1'b0;
  endfunction

  task automatic modelEdge(input bit v, input logic [PAT_W-1:0] pat, input bit sg, input bit dOut);
    bit rdy, acc, armedBefore, counted;
    if (!clr) begin
      modelReset();
    end else begin
      rdy         = mIdle || (mAge >= 2*PAT_W);
      acc         = v && rdy;
      armedBefore = !mIdle && (mAge >= 2*PAT_W + 1);
      counted     = armedBefore && dOut && !acc;
      if (acc) begin
        mIdle = 1'b0; mAge = 0; mPat = pat; mCount = 0; mOvf = 1'b0;
      end else if (!mIdle && mAge < 1000) begin
        mAge++;
      end
      if (counted) begin
        if (mCount == CNT_MAX) mOvf = 1'b1;
        else mCount++;
      end
      mPulse = counted;
      mSig   = (!mIdle && mAge >= PAT_W + 1) ? sg : 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag);
    bit expEn, expPrgm;
    expEn   = !mIdle && mAge >= 1 && mAge <= PAT_W;
    expPrgm = expEn ? mPat[PAT_W - mAge] : 1'b0;
    cmp($sformatf("%s.cfg_ready", tag), int'(cfg_ready), int'(mIdle || mAge >= 2*PAT_W));
    cmp($sformatf("%s.dec_enable", tag), int'(dec_enable), int'(expEn));
    cmp($sformatf("%s.dec_prgm", tag), int'(dec_prgm), int'(expPrgm));
    cmp($sformatf("%s.dec_sig", tag), int'(dec_sig), int'(mSig));
    cmp($sformatf("%s.armed", tag), int'(armed), int'(!mIdle && mAge >= 2*PAT_W + 1));
    cmp($sformatf("%s.match_pulse", tag), int'(match_pulse), int'(mPulse));
    cmp($sformatf("%s.match_count", tag), int'(match_count), mCount);
`ifdef DEC4_CTRL_OVF_EN
    cmp($sformatf("%s.cnt_ovf", tag), int'(cnt_ovf), int'(mOvf));
`endif
  endtask

  task automatic applyStimulus(input bit v, input logic [PAT_W-1:0] pat, input bit sg,
                               input bit dOutForce, input string tag);
    bit sampled;
    cfg_valid   = v;
    cfg_pattern = pat;
    sig_in      = sg;
    decOutDrv   = dOutForce;
    #1;
    sampled = dec_out;
    @(posedge clk);
    modelEdge(v, pat, sg, sampled);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [15:0]      sigBits;
    logic [PAT_W-1:0] reloadPat;
    int               pulses, enCount;

    // Programming sequence for 4'b1010 with cfg_valid held through the hold-off window.
    vecs[0]  = '{1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1010, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1010, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1};

    #12;
    modelReset();
    checkOutput("reset");
    cmp("reset.cfg_ready_idle", int'(cfg_ready), 1);
    clr = 1'b1;

    $display("[TB] test 1: program 1010");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].pattern, 1'b0, 1'b0, $sformatf("t1[%0d]", i));
      cmp($sformatf("t1tab[%0d].ready", i), int'(cfg_ready), int'(vecs[i].expReady));
      cmp($sformatf("t1tab[%0d].enable", i), int'(dec_enable), int'(vecs[i].expEnable));
      cmp($sformatf("t1tab[%0d].prgm", i), int'(dec_prgm), int'(vecs[i].expPrgm));
      cmp($sformatf("t1tab[%0d].armed", i), int'(armed), int'(vecs[i].expArmed));
    end

    $display("[TB] test 2: match counting with decoder model");
    useDecModel = 1'b1;
    sigBits = 16'b0101000101000000;
    pulses = 0;
    for (int i = 0; i < 22; i++) begin
      applyStimulus(1'b0, '0, (i < 16) ? sigBits[15-i] : 1'b0, 1'b0, $sformatf("t2[%0d]", i));
      if (match_pulse) pulses++;
    end
    cmp("t2.match_count", int'(match_count), 2);
    cmp("t2.pulse_cycles", pulses, 2);
    useDecModel = 1'b0;

    $display("[TB] test 3: flush blanking");
    applyStimulus(1'b1, 4'b0011, 1'b0, 1'b1, "t3.accept");
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b0, '0, 1'(($urandom)), 1'b1, $sformatf("t3[%0d]", i));
      cmp($sformatf("t3blank[%0d].count", i), int'(match_count), 0);
      cmp($sformatf("t3blank[%0d].pulse", i), int'(match_pulse), 0);
    end
    cmp("t3.armed_rise", int'(armed), 1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, $sformatf("t3c[%0d]", i));
    cmp("t3.count_five", int'(match_count), 5);

    $display("[TB] test 4: reprogram collision");
    applyStimulus(1'b1, 4'b0110, 1'b0, 1'b1, "t4.accept");
    cmp("t4.count_cleared", int'(match_count), 0);
    cmp("t4.pulse_suppressed", int'(match_pulse), 0);
    reloadPat = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, $sformatf("t4[%0d]", i));
      cmp($sformatf("t4.prgm_bit%0d", i), int'(dec_prgm), int'(reloadPat[3-i]));
    end

    $display("[TB] test 5: saturation");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, $sformatf("t5w[%0d]", i));
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, $sformatf("t5[%0d]", i));
    cmp("t5.saturated", int'(match_count), CNT_MAX);
`ifdef DEC4_CTRL_OVF_EN
    cmp("t5.cnt_ovf", int'(cnt_ovf), 1);
`endif

    $display("[TB] test 6: async reset mid-load");
    applyStimulus(1'b1, 4'b1001, 1'b0, 1'b0, "t6.accept");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "t6.bit0");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "t6.bit1");
    #2;
    clr = 1'b0;
    #1;
    modelReset();
    checkOutput("t6.in_reset");
    cmp("t6.enable_dropped", int'(dec_enable), 0);
    cmp("t6.ready_idle", int'(cfg_ready), 1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0, $sformatf("t6h[%0d]", i));
    clr = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1, $sformatf("t6i[%0d]", i));
    applyStimulus(1'b1, 4'b1100, 1'b0, 1'b0, "t6.reaccept");
    enCount = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b0, $sformatf("t6r[%0d]", i));
      if (dec_enable) enCount++;
    end
    cmp("t6.full_load", enCount, 4);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, PAT_W'($urandom), 1'($urandom),
                    1'($urandom), $sformatf("rnd[%0d]", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
